// File: rtl/scan_pkg.sv
// Shared types and constants for the channel scan sequencer.
package scan_pkg;

  localparam int DWELL_W_DEF = 8;
  localparam int N_CHAN      = 8;
  localparam int CHAN_W      = $clog2(N_CHAN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [CHAN_W-1:0] lowest_chan(input logic [N_CHAN-1:0] m);
    lowest_chan = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (m[i]) lowest_chan = CHAN_W'(i);
    end
  endfunction

endpackage

// File: rtl/scan_seq_if.sv
// Control and decoder-drive signals of the scan sequencer.
interface scan_seq_if #(
  parameter int DWELL_W = scan_pkg::DWELL_W_DEF
);
  logic               start;
  logic               stop;
  logic               loop;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic               enable;
  logic               a;
  logic               b;
  logic               c;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, loop, mask, dwell,
    input  enable, a, b, c, busy, done
  );

  modport slave (
    input  start, stop, loop, mask, dwell,
    output enable, a, b, c, busy, done
  );
endinterface

// File: rtl/next_chan_find.sv
// Finds the next higher enabled channel after cur_idx, or wraps to the lowest one.
module next_chan_find
  import scan_pkg::*;
(
  input  logic [N_CHAN-1:0] mask,
  input  logic [CHAN_W-1:0] cur_idx,
  output logic [CHAN_W-1:0] next_idx,
  output logic              wrap,
  output logic              found
);

  // NOTE: every output gets a default first, so no path leaves a latch behind.
  always_comb begin
    next_idx = lowest_chan(mask);
    wrap     = 1'b1;
    found    = |mask;
    // Walk downwards so the closest higher channel is the last one written.
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (i > int'(cur_idx) && mask[i]) begin
        next_idx = CHAN_W'(i);
        wrap     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/scan_seq.sv
// Scan sequencer: steps a 3-to-8 decoder through the enabled channels with a fixed dwell.
module scan_seq
  import scan_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF
) (
  input logic       clk,
  input logic       rst_n,
  scan_seq_if.slave bus
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  scan_state_e        state, state_d;
  logic [CHAN_W-1:0]  chan, chan_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [N_CHAN-1:0]  mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [CHAN_W-1:0]  nf_next;
  logic               nf_wrap;
  logic               nf_found;

  assign dwell_eff = (dwell_q == '0) ? ONE : dwell_q;

  next_chan_find u_find (
    .mask     (mask_q),
    .cur_idx  (chan),
    .next_idx (nf_next),
    .wrap     (nf_wrap),
    .found    (nf_found)
  );

  always_comb begin
    state_d  = state;
    chan_d   = chan;
    cnt_d    = cnt;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    loop_d   = loop_q;
    enable_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          mask_d  = bus.mask;
          dwell_d = bus.dwell;
          loop_d  = bus.loop;
          if (|bus.mask) begin
            state_d  = SCAN;
            chan_d   = lowest_chan(bus.mask);
            cnt_d    = ONE;
            enable_d = 1'b1;
            busy_d   = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      SCAN: begin
        // Abort wins over every other transition out of a dwell.
        if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt < dwell_eff) begin
          cnt_d    = cnt + ONE;
          enable_d = 1'b1;
          busy_d   = 1'b1;
        end else if (nf_found && (!nf_wrap || loop_q)) begin
          chan_d   = nf_next;
          cnt_d    = ONE;
          enable_d = 1'b1;
          busy_d   = 1'b1;
        end else begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is asynchronous (in the sensitivity list) and all state uses non-blocking <=.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chan     <= '0;
      cnt      <= '0;
      mask_q   <= '0;
      dwell_q  <= '0;
      loop_q   <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_d;
      chan     <= chan_d;
      cnt      <= cnt_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      loop_q   <= loop_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.enable              = enable_q;
  assign bus.busy                = busy_q;
  assign bus.done                = done_q;
  assign {bus.a, bus.b, bus.c}   = chan;

endmodule

// File: tb/tb_scan_seq.sv
// Randomized and directed bench for scan_seq against a queue-based output model.
module tb_scan_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  scan_seq_if #(.DWELL_W(8)) bus ();

  scan_seq #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output word per cycle: {enable, busy, done, code}.
  typedef struct packed {
    logic       en;
    logic       busy;
    logic       done;
    logic [2:0] code;
  } obs_t;

  obs_t       want;
  obs_t       plan[$];
  logic [7:0] m_mask;
  int         m_dw;
  logic       m_loop;
  logic [7:0] dline;

  function automatic obs_t mk(input logic en, input logic busy, input logic done,
                              input logic [2:0] code);
    obs_t o;
    o.en = en; o.busy = busy; o.done = done; o.code = code;
    return o;
  endfunction

  // One full pass: every enabled channel, ascending, held m_dw cycles.
  function void fill_pass();
    for (int ch = 0; ch < 8; ch++) begin
      if (m_mask[ch]) begin
        for (int k = 0; k < m_dw; k++) plan.push_back(mk(1'b1, 1'b1, 1'b0, 3'(ch)));
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      plan.delete();
      want   = '0;
      m_mask = '0;
      m_dw   = 1;
      m_loop = 1'b0;
    end else if (want.busy && bus.stop) begin
      plan.delete();
      want = mk(1'b0, 1'b0, 1'b0, want.code);
    end else if (!want.busy && !want.done && bus.start) begin
      m_mask = bus.mask;
      m_dw   = (bus.dwell == 0) ? 1 : int'(bus.dwell);
      m_loop = bus.loop;
      if (bus.mask == 0) want = mk(1'b0, 1'b0, 1'b1, want.code);
      else begin
        fill_pass();
        want = plan.pop_front();
      end
    end else if (plan.size() > 0) begin
      want = plan.pop_front();
    end else if (want.busy) begin
      if (m_loop) begin
        fill_pass();
        want = plan.pop_front();
      end else want = mk(1'b0, 1'b0, 1'b1, want.code);
    end else begin
      want = mk(1'b0, 1'b0, 1'b0, want.code);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [2:0] code();
    return {bus.a, bus.b, bus.c};
  endfunction

  always_comb dline = bus.enable ? (8'b1 << code()) : 8'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("model", 32'({bus.enable, bus.busy, bus.done, bus.a, bus.b, bus.c}), 32'(want));
      check("decoder_onehot", 32'($countones(dline)), bus.enable ? 32'd1 : 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] m, input int d, input logic l);
    bus.mask  = m;
    bus.dwell = 8'(d);
    bus.loop  = l;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    int         seen;
    logic       got_done;
    logic [2:0] seq2 [9];
    logic [2:0] seq6 [8];
    logic [7:0] rm;

    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    bus.mask  = '0;
    bus.dwell = '0;
    #12;
    check("reset_outputs", 32'({bus.enable, bus.busy, bus.done, bus.a, bus.b, bus.c}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Full mask, one cycle per channel, single pass.
    do_start(8'hFF, 1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("ff_code", 32'(code()), 32'(i));
      check("ff_enable", 32'(bus.enable), 32'd1);
      cyc();
    end
    check("ff_done", 32'({bus.enable, bus.busy, bus.done}), 32'b001);
    cyc();
    check("ff_done_once", 32'(bus.done), 32'd0);

    // Sparse mask, dwell 3.
    seq2 = '{3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd7, 3'd7, 3'd7};
    do_start(8'b1010_0100, 3, 1'b0);
    for (int i = 0; i < 9; i++) begin
      check("sparse_code", 32'(code()), 32'(seq2[i]));
      cyc();
    end
    check("sparse_done", 32'({bus.enable, bus.done, bus.a, bus.b, bus.c}), 32'b01_111);
    cyc();

    // Two-channel loop with dwell 0, then abort.
    do_start(8'h81, 0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      check("loop_code", 32'(code()), (i % 2 == 1) ? 32'd7 : 32'd0);
      check("loop_enable", 32'(bus.enable), 32'd1);
      cyc();
    end
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    check("stop_outputs", 32'({bus.enable, bus.busy, bus.done}), 32'b000);
    cyc();
    check("stop_no_done", 32'(bus.done), 32'd0);

    // Empty mask completes immediately.
    do_start(8'h00, 2, 1'b0);
    check("empty_done", 32'({bus.enable, bus.busy, bus.done}), 32'b001);
    cyc();
    check("empty_after", 32'({bus.enable, bus.done}), 32'b00);

    // Reset mid-dwell on channel 4.
    do_start(8'b0001_0010, 5, 1'b0);
    for (int i = 0; i < 6; i++) cyc();
    check("pre_reset_code", 32'(code()), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({bus.enable, bus.busy, bus.done, bus.a, bus.b, bus.c}), 32'd0);
    cyc();
    cyc();
    check("reset_no_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(8'b0001_0010, 5, 1'b0);
    check("restart_lowest", 32'({bus.enable, bus.a, bus.b, bus.c}), 32'b1_001);
    bus.stop = 1'b1;
    cyc();
    bus.stop = 1'b0;
    cyc();

    // Second start and changed inputs during a scan are ignored.
    seq6 = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};
    do_start(8'h0F, 2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("ignore_code", 32'(code()), 32'(seq6[i]));
      if (i == 3) begin
        bus.mask  = 8'hF0;
        bus.dwell = 8'd7;
        bus.loop  = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
      end else cyc();
    end
    check("ignore_done", 32'(bus.done), 32'd1);
    cyc();

    // Maximum dwell holds without counter wrap.
    do_start(8'h01, 255, 1'b0);
    seen     = 0;
    got_done = 1'b0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      if (bus.enable) seen++;
      if (bus.done) got_done = 1'b1;
      else cyc();
    end
    check("max_dwell_len", 32'(seen), 32'd255);
    check("max_dwell_done", 32'(got_done), 32'd1);
    cyc();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rm = 8'($urandom);
      if ($urandom % 5 == 0) rm = 8'h00;
      else if ($urandom % 4 == 0) rm = 8'(1 << ($urandom % 8));
      bus.mask  = rm;
      bus.dwell = 8'($urandom % 4);
      bus.loop  = 1'($urandom % 2);
      bus.start = ($urandom % 6 == 0);
      bus.stop  = ($urandom % 24 == 0);
      cyc();
    end
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    cyc();
    bus.stop = 1'b0;
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
